// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    RETRY,
    DONE
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == RD_ID) || (s == RD_TS) || (s == CHECK) || (s == RETRY);
  endfunction

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Counts stalled read cycles; flags the cycle whose stall reaches the limit.
module sysid_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Expires on the edge that would complete the TIMEOUT_CYCLES-th stalled cycle.
  assign o_expired_c = i_enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, timestamp), compares
// against build-time values and reports pass/fail, with per-read timeout and retry.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'd1418799084,
  parameter bit                      CHECK_TS       = 1'b1,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter int unsigned             MAX_RETRIES    = 3,
  parameter bit                      AUTO_START     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] read_id,
  output logic [SYSID_DATA_W-1:0] read_ts,
  output logic [3:0]              retry_cnt
);

  localparam int unsigned RETRY_W = 4;

  state_t r_state, w_state_nxt;

  logic r_start_q, r_armed;
  logic w_launch, w_rd_ok, w_stall, w_expired, w_ctr_clear;
  logic r_read, w_read_nxt;
  logic r_addr, w_addr_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_pass, w_pass_nxt;
  logic r_idmm, w_idmm_nxt;
  logic r_tsmm, w_tsmm_nxt;
  logic r_tmo, w_tmo_nxt;
  logic [SYSID_DATA_W-1:0] r_read_id, w_read_id_nxt;
  logic [SYSID_DATA_W-1:0] r_read_ts, w_read_ts_nxt;
  logic [RETRY_W-1:0]      r_retry, w_retry_nxt;

  assign w_rd_ok     = r_read && !avm_waitrequest;
  assign w_stall     = r_read && avm_waitrequest;
  assign w_ctr_clear = !r_read || w_rd_ok || w_expired;

  // Auto-start fires once, on the first cycle after reset releases.
  assign w_launch = ((r_state == IDLE) && (r_start_q || (AUTO_START && !r_armed)))
                 || ((r_state == DONE) && r_start_q);

  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_clear    (w_ctr_clear),
    .i_enable   (w_stall),
    .o_expired_c(w_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
      r_read    <= 1'b0;
      r_addr    <= SYSID_ADDR_ID;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_idmm    <= 1'b0;
      r_tsmm    <= 1'b0;
      r_tmo     <= 1'b0;
      r_read_id <= '0;
      r_read_ts <= '0;
      r_retry   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start && !r_busy && !w_launch;
      r_armed   <= 1'b1;
      r_read    <= w_read_nxt;
      r_addr    <= w_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_idmm    <= w_idmm_nxt;
      r_tsmm    <= w_tsmm_nxt;
      r_tmo     <= w_tmo_nxt;
      r_read_id <= w_read_id_nxt;
      r_read_ts <= w_read_ts_nxt;
      r_retry   <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_read_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_idmm_nxt    = r_idmm;
    w_tsmm_nxt    = r_tsmm;
    w_tmo_nxt     = r_tmo;
    w_read_id_nxt = r_read_id;
    w_read_ts_nxt = r_read_ts;
    w_retry_nxt   = r_retry;

    case (r_state)
      IDLE, DONE: begin
        if (w_launch) begin
          w_state_nxt = RD_ID;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_idmm_nxt  = 1'b0;
          w_tsmm_nxt  = 1'b0;
          w_tmo_nxt   = 1'b0;
          w_retry_nxt = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (w_expired) begin
          if (r_retry < RETRY_W'(MAX_RETRIES)) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = RETRY;
          end else begin
            w_tmo_nxt   = 1'b1;
            w_pass_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (w_rd_ok) begin
          if (r_state == RD_ID) begin
            w_read_id_nxt = avm_readdata;
            w_state_nxt   = RD_TS;
          end else begin
            w_read_ts_nxt = avm_readdata;
            w_state_nxt   = CHECK;
          end
        end
      end
      CHECK: begin
        w_idmm_nxt  = (r_read_id != EXPECTED_ID);
        w_tsmm_nxt  = (r_read_ts != EXPECTED_TS);
        w_pass_nxt  = !w_idmm_nxt && !(CHECK_TS && w_tsmm_nxt);
        w_done_nxt  = 1'b1;
        w_state_nxt = DONE;
      end
      RETRY: begin
        w_state_nxt = RD_ID;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Bus strobes and busy follow the next state so they leave registers aligned to it.
    w_read_nxt = (w_state_nxt == RD_ID) || (w_state_nxt == RD_TS);
    if (w_state_nxt == RD_ID) begin
      w_addr_nxt = SYSID_ADDR_ID;
    end else if (w_state_nxt == RD_TS) begin
      w_addr_nxt = SYSID_ADDR_TS;
    end
    w_busy_nxt = is_busy_state(w_state_nxt);
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_mismatch = r_idmm;
  assign ts_mismatch = r_tsmm;
  assign timeout     = r_tmo;
  assign read_id     = r_read_id;
  assign read_ts     = r_read_ts;
  assign retry_cnt   = r_retry;

endmodule
